// File: rtl/skyline_stream.sv
// Skyline outline over a ready/valid stream of (left, height, right) triples; emits (x, height) vertices.
// Optional SKYLINE_AREA_EN: accumulate the skyline area and present it on AREA with OUT_DONE.
module skyline_stream #(
  parameter int NUM_BLD = 8,
  parameter int COORD_W = 6,
  parameter int MAP_W   = 31
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [COORD_W-1:0]   IN_DATA,
  input  logic                 IN_LAST,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [COORD_W-1:0]   OUT_DATA,
  output logic                 OUT_DONE,
  output logic                 ERR,
  output logic [2*COORD_W-1:0] AREA
);

  localparam int CNT_W = $clog2(NUM_BLD + 1);
  localparam logic [COORD_W-1:0] MAP_X   = COORD_W'(MAP_W);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(NUM_BLD);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT_X, EMIT_H, DONE} state_t;

  state_t               state;
  logic [1:0]           field;
  logic [COORD_W-1:0]   cur_l, cur_h, x, prev, col_h;
  logic [COORD_W-1:0]   bld_l [NUM_BLD];
  logic [COORD_W-1:0]   bld_h [NUM_BLD];
  logic [COORD_W-1:0]   bld_r [NUM_BLD];
  logic [NUM_BLD-1:0]   bld_vld;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 accept, bld_ok, frame_end;

  assign IN_READY  = (state == IDLE) || (state == LOAD);
  assign accept    = IN_VALID && IN_READY;
  assign bld_ok    = (cur_l < IN_DATA) && (IN_DATA <= MAP_X);
  assign cnt_nxt   = bld_ok ? cnt + CNT_W'(1) : cnt;
  assign frame_end = IN_LAST || (cnt_nxt == CNT_MAX);

  // Half-open column test; right <= MAP_W guarantees h(MAP_W) = 0.
  always_comb begin
    col_h = '0;
    for (int i = 0; i < NUM_BLD; i++) begin
      if (bld_vld[i] && (bld_l[i] <= x) && (x < bld_r[i]) && (bld_h[i] > col_h))
        col_h = bld_h[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      field     <= 2'd0;
      cnt       <= '0;
      bld_vld   <= '0;
      cur_l     <= '0;
      cur_h     <= '0;
      x         <= '0;
      prev      <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_DONE  <= 1'b0;
      ERR       <= 1'b0;
      for (int i = 0; i < NUM_BLD; i++) begin
        bld_l[i] <= '0;
        bld_h[i] <= '0;
        bld_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            case (field)
              2'd0: begin
                cur_l <= IN_DATA;
                field <= 2'd1;
                if (state == IDLE) begin
                  state <= LOAD;
                  ERR   <= 1'b0;
                end
              end
              2'd1: begin
                cur_h <= IN_DATA;
                field <= 2'd2;
              end
              default: begin
                field <= 2'd0;
                if (bld_ok) begin
                  bld_l[cnt]   <= cur_l;
                  bld_h[cnt]   <= cur_h;
                  bld_r[cnt]   <= IN_DATA;
                  bld_vld[cnt] <= 1'b1;
                  cnt          <= cnt_nxt;
                end else begin
                  ERR <= 1'b1;
                end
                if (frame_end) begin
                  state <= SCAN;
                  x     <= '0;
                  prev  <= '0;
                end
              end
            endcase
          end
        end
        SCAN: begin
          if (col_h != prev) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= x;
            state     <= EMIT_X;
          end else if (x == MAP_X) begin
            state    <= DONE;
            OUT_DONE <= 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        EMIT_X: begin
          if (OUT_READY) begin
            OUT_DATA <= col_h;
            state    <= EMIT_H;
          end
        end
        EMIT_H: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            prev      <= col_h;
            if (x == MAP_X) begin
              state    <= DONE;
              OUT_DONE <= 1'b1;
            end else begin
              x     <= x + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          OUT_DONE <= 1'b0;
          state    <= IDLE;
          cnt      <= '0;
          bld_vld  <= '0;
          field    <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKYLINE_AREA_EN
  logic [2*COORD_W-1:0] area;

  // Each column is visited exactly once in SCAN, so summing there counts it once.
  always_ff @(posedge CLK) begin
    if (!RESET)
      area <= '0;
    else if ((state == IDLE) && accept)
      area <= '0;
    else if ((state == SCAN) && (x != MAP_X))
      area <= area + {{COORD_W{1'b0}}, col_h};
  end

  assign AREA = area;
`else
  assign AREA = '0;
`endif

endmodule

// File: tb/tb_skyline_stream.sv
// Directed bench for skyline_stream: vertex streams, backpressure, invalid drops, full frames, mid-frame reset.
module tb_skyline_stream;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID, IN_LAST, IN_READY;
  logic [5:0]  IN_DATA;
  logic        OUT_VALID, OUT_READY, OUT_DONE, ERR;
  logic [5:0]  OUT_DATA;
  logic [11:0] AREA;

  int n_chk = 0;
  int n_err = 0;
  int got_q[$];
  int exp_q[$];
  logic done_seen, err_seen;
  logic [11:0] area_seen;

  skyline_stream #(.NUM_BLD(8), .COORD_W(6), .MAP_W(31)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_DONE(OUT_DONE), .ERR(ERR), .AREA(AREA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [5:0] d, input logic l);
    int w = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = l;
    while (!IN_READY && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 100) check("in_timeout", 0, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic send_bld(input logic [5:0] l, input logic [5:0] h, input logic [5:0] r, input logic last);
    send_word(l, 1'b0);
    send_word(h, 1'b1);   // IN_LAST on a height word must be ignored
    send_word(r, last);
  endtask

  task automatic collect(input bit stall);
    bit held = 0;
    got_q.delete();
    done_seen = 1'b0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      @(negedge CLK);
      if (OUT_DONE) begin
        done_seen = 1'b1;
        area_seen = AREA;
        err_seen  = ERR;
      end else begin
        if (stall && !held && OUT_VALID && OUT_DATA == 6'd4) begin
          held = 1;
          OUT_READY = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            check("hold_vld", OUT_VALID, 1);
            check("hold_dat", OUT_DATA, 4);
          end
          OUT_READY = 1'b1;
        end
        if (OUT_VALID && OUT_READY) got_q.push_back(int'(OUT_DATA));
      end
    end
    check("done_seen", done_seen, 1);
    @(negedge CLK);
    check("done_pulse", OUT_DONE, 0);
    check("idle_rdy", IN_READY, 1);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
  endtask

  task automatic chk_area(input string tag, input int exp);
`ifdef SKYLINE_AREA_EN
    check(tag, area_seen, exp);
`else
    check(tag, area_seen, 0);
`endif
  endtask

  initial begin
    int w, nd;
    RESET = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ovld", OUT_VALID, 0);
    check("rst_odat", OUT_DATA, 0);
    check("rst_done", OUT_DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_area", AREA, 0);
    check("rst_irdy", IN_READY, 1);
    RESET = 1'b1;
    @(negedge CLK);

    // Two overlapping buildings
    send_bld(2, 5, 6, 1'b0);
    send_bld(4, 8, 9, 1'b1);
    check("t1_busy", IN_READY, 0);
    collect(0);
    exp_q = '{2, 5, 4, 8, 9, 0};
    cmp_stream("t1");
    chk_area("t1_area", 50);
    check("t1_err", err_seen, 0);

    // Same frame with a 5-cycle stall on the x=4 word
    send_bld(2, 5, 6, 1'b0);
    send_bld(4, 8, 9, 1'b1);
    collect(1);
    cmp_stream("t4");
    chk_area("t4_area", 50);

    // Seam of equal heights, then an invalid (zero-width) building
    send_bld(1, 4, 3, 1'b0);
    send_bld(3, 4, 5, 1'b0);
    send_bld(7, 3, 7, 1'b1);
    collect(0);
    exp_q = '{1, 4, 5, 0};
    cmp_stream("t3");
    check("t3_err", err_seen, 1);
    chk_area("t3_area", 16);
    check("err_hold", ERR, 1);

    // Full-width building; ERR clears on the first accepted word
    send_word(0, 1'b0);
    check("err_clr", ERR, 0);
    send_word(10, 1'b0);
    send_word(31, 1'b1);
    collect(0);
    exp_q = '{0, 10, 31, 0};
    cmp_stream("t2");
    chk_area("t2_area", 310);

    // Eight triples, IN_LAST never set: the frame ends on count
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_word(6'(3*i), 1'b0);
      send_word(6'(i+1), 1'b0);
      send_word(6'(3*i+2), 1'b0);
      exp_q.push_back(3*i);   exp_q.push_back(i+1);
      exp_q.push_back(3*i+2); exp_q.push_back(0);
    end
    check("t5_rdy_low", IN_READY, 0);
    collect(0);
    cmp_stream("t5");
    chk_area("t5_area", 72);

    // Only an invalid building (right beyond the map)
    send_bld(5, 3, 40, 1'b1);
    collect(0);
    exp_q.delete();
    cmp_stream("t6");
    check("t6_err", err_seen, 1);

    // Reset pulse during EMIT_H
    send_bld(2, 5, 6, 1'b0);
    send_bld(4, 8, 9, 1'b1);
    OUT_READY = 1'b0;
    w = 0;
    while (!OUT_VALID && w < 100) begin
      @(negedge CLK);
      w++;
    end
    check("rst_wait", OUT_VALID, 1);
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("emit_h_dat", OUT_DATA, 5);
    OUT_READY = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    check("mid_ovld", OUT_VALID, 0);
    check("mid_odat", OUT_DATA, 0);
    check("mid_irdy", IN_READY, 1);
    nd = 0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (OUT_DONE) nd++;
    end
    check("mid_nodone", nd, 0);
    send_bld(2, 5, 6, 1'b0);
    send_bld(4, 8, 9, 1'b1);
    collect(0);
    exp_q = '{2, 5, 4, 8, 9, 0};
    cmp_stream("t7");
    chk_area("t7_area", 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/skyline_stream.md
Name: skyline_stream

Overview:
Parametrised successor to the fixed 8-building skyline sketcher. Accepts a variable-length frame of up to NUM_BLD building triples (left, height, right) over a ready/valid stream and computes the skyline outline column by column. It emits the key vertices (x, height) as a backpressured output stream, then pulses a frame-done indication. It sits between the building-data source and the vertex consumer in the skyline datapath.

Parameters:
NUM_BLD, 8, maximum buildings per frame (≥1)
COORD_W, 6, width of every coordinate/height word
MAP_W, 31, number of map columns 0..MAP_W-1; must satisfy MAP_W ≤ 2^COORD_W-1

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  reset, synchronous, active-low
IN_VALID  input  1  input word valid
IN_READY  output  1  block can accept input words
IN_DATA  input  COORD_W  input word; field order per building: left, height, right
IN_LAST  input  1  marks the final building; sampled only with the right field
OUT_VALID  output  1  output word valid
OUT_READY  input  1  consumer accepts output word
OUT_DATA  output  COORD_W  vertex stream: x, then height
OUT_DONE  output  1  one-cycle pulse, frame complete
ERR  output  1  sticky per frame, an invalid building was dropped
AREA  output  2*COORD_W  skyline area, valid while OUT_DONE (optional feature)

Behaviour:
- Reset (RESET=0 at edge): state IDLE, building store cleared, field/building counters 0, OUT_VALID=0, OUT_DATA=0, OUT_DONE=0, ERR=0, AREA=0. A mid-frame reset aborts the frame with no OUT_DONE.
- IN_READY=1 only in IDLE/LOAD. A word is accepted on IN_VALID&IN_READY. Field counter cycles 0→1→2; IDLE moves to LOAD on the first accepted word.
- On field 2 the building is validated: left<right and right≤MAP_W. Valid buildings are stored and the count is incremented. Invalid buildings are dropped and ERR is set. Height 0 is valid but has no effect.
- A frame ends on the accepted field-2 word when IN_LAST=1 or when the stored count reaches NUM_BLD. IN_LAST on fields 0/1 is ignored. The next cycle the state is SCAN with x=0 and prev=0.
- Column height h(x) = max height over stored buildings with left≤x<right (half-open), else 0. h(MAP_W)=0.
- SCAN, one column per cycle for x=0..MAP_W:
  - if h(x)≠prev: register OUT_VALID=1, OUT_DATA=x, go to EMIT_X;
  - else prev=h(x); if x=MAP_W go to DONE, otherwise x+1.
- EMIT_X: hold OUT_DATA/OUT_VALID until OUT_READY. On handshake, OUT_DATA=h(x) and go to EMIT_H.
- EMIT_H: on handshake, OUT_VALID=0 and prev=h(x). Go to DONE if x=MAP_W, else x+1 and SCAN.
- Minimum cost is 3 cycles per vertex and 1 per flat column. OUT_DATA is stable while OUT_VALID&!OUT_READY.
- DONE: OUT_DONE=1 for one cycle. Next state IDLE, store and counters cleared. ERR holds until the first word of the next frame is accepted.
- Equal-height adjacent buildings produce no vertex at the seam. A frame with no valid buildings emits nothing, then OUT_DONE.
- Coordinates compare unsigned. x counter width is COORD_W.

Optional Feature:
SKYLINE_AREA_EN
- Defined: an accumulator adds h(x) each scanned column (x<MAP_W) and is cleared at frame start. AREA presents the sum during the OUT_DONE cycle and holds it until the next frame starts.
- Undefined: no accumulator; AREA tied to 0.

Test Plan:
- (2,5,6),(4,8,9) with IN_LAST on the second triple → OUT_DATA 2,5,4,8,9,0 then OUT_DONE; AREA=50 with feature.
- (0,10,31) single building → 0,10,31,0; AREA=310.
- (1,4,3),(3,4,5),(7,3,7) last → 1,4,5,0; ERR=1; third building dropped.
- OUT_READY low 5 cycles while OUT_DATA=4 (first case) → OUT_DATA/OUT_VALID held; stream unchanged after release.
- 8 triples with IN_LAST never asserted → IN_READY drops after the 24th word; scan completes; OUT_DONE pulses.
- RESET low for one cycle during EMIT_H → OUT_VALID=0 next cycle, no OUT_DONE; the next frame processes correctly.
